wb4_to_pi1: RTL

Pipelined Wishbone4 slave to PI1 master bridge, the stage directly downstream of the PI1-to-WB4 master bridge. It lets PI1 peripherals and memories sit on a Wishbone4 bus. Requests are buffered in a 2-entry in-order queue and issued as PI1 read or write ops. Completions return as single-cycle WB4 acks in request order.

---
 rtl/wb4_to_pi1_pkg.sv | 20 ++
 rtl/wb4_to_pi1_reqq.sv | 52 +++++
 rtl/wb4_to_pi1.sv | 117 +++++++++++
 3 files changed

// File: rtl/wb4_to_pi1_pkg.sv
// Shared PI1 definitions: op codes and the constant clog2 helper used to size
// the word-address bus.
package wb4_to_pi1_pkg;

  typedef enum logic [1:0] {
    PINOOP = 2'b00,
    PIWROP = 2'b01,
    PIRDOP = 2'b10,
    PIRWOP = 2'b11
  } pi1_op_t;

  function automatic int clog2(input int value);
    int result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/wb4_to_pi1_reqq.sv
// Two-entry in-order request queue; flush empties it in one cycle and takes
// priority over push/pop.
module wb4_to_pi1_reqq #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] push_data,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb4_to_pi1.sv
// Pipelined Wishbone4 slave to PI1 master bridge: requests queue in order,
// issue on PI1 from the queue head, and complete as single-cycle WB4 acks.
module wb4_to_pi1
  import wb4_to_pi1_pkg::*;
#(
  parameter  int ARCHBITSZ = 32,
  localparam int ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ / 8)
) (
  input  logic                   rst_i,
  input  logic                   clk_i,
  input  logic                   wb4_cyc_i,
  input  logic                   wb4_stb_i,
  input  logic                   wb4_we_i,
  input  logic [ARCHBITSZ-1:0]   wb4_addr_i,
  input  logic [ARCHBITSZ-1:0]   wb4_data_i,
  input  logic [ARCHBITSZ/8-1:0] wb4_sel_i,
  output logic                   wb4_stall_o,
  output logic                   wb4_ack_o,
  output logic [ARCHBITSZ-1:0]   wb4_data_o,
  output logic [1:0]             pi1_op_o,
  output logic [ADDRBITSZ-1:0]   pi1_addr_o,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  output logic [ARCHBITSZ/8-1:0] pi1_sel_o,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  input  logic                   pi1_rdy_i
);

  localparam int SELBITSZ = ARCHBITSZ / 8;
  localparam int ENTRYSZ  = 1 + ADDRBITSZ + ARCHBITSZ + SELBITSZ;

  logic               q_full;
  logic               q_empty;
  logic [ENTRYSZ-1:0] q_head;
  logic               accept;
  logic               issue_valid;
  logic               issue;
  logic               complete;
  logic               inflight;
  logic               inflight_we;
  logic               inflight_drop;
  pi1_op_t            op;

  logic                 head_we;
  logic [ADDRBITSZ-1:0] head_addr;
  logic [ARCHBITSZ-1:0] head_data;
  logic [SELBITSZ-1:0]  head_sel;

  // Byte-offset bits are irrelevant: lane selection comes only from sel.
  logic unused_addr_lo;
  assign unused_addr_lo = &{1'b0, wb4_addr_i[ARCHBITSZ-ADDRBITSZ-1:0]};

  assign accept      = wb4_cyc_i && wb4_stb_i && !q_full;
  assign issue_valid = wb4_cyc_i && !q_empty;
  assign issue       = issue_valid && pi1_rdy_i;
  assign complete    = pi1_rdy_i && inflight && !inflight_drop;
  assign wb4_stall_o = q_full;

  assign head_we   = q_head[ENTRYSZ-1];
  assign head_addr = q_head[ENTRYSZ-2 -: ADDRBITSZ];
  assign head_data = q_head[SELBITSZ +: ARCHBITSZ];
  assign head_sel  = q_head[SELBITSZ-1:0];

  wb4_to_pi1_reqq #(.W(ENTRYSZ)) u_reqq (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (accept),
    .pop       (issue),
    .flush     (!wb4_cyc_i),
    .push_data ({wb4_we_i, wb4_addr_i[ARCHBITSZ-1 -: ADDRBITSZ], wb4_data_i, wb4_sel_i}),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head)
  );

  // The PI1 side shows the queue head only while the bus cycle is alive.
  always_comb begin
    op         = PINOOP;
    pi1_addr_o = '0;
    pi1_data_o = '0;
    pi1_sel_o  = '0;
    if (issue_valid) begin
      op         = head_we ? PIWROP : PIRDOP;
      pi1_addr_o = head_addr;
      pi1_data_o = head_data;
      pi1_sel_o  = head_sel;
    end
  end

  assign pi1_op_o = op;

  // An op aborted by dropping cyc still finishes on PI1 but must not ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight      <= 1'b0;
      inflight_we   <= 1'b0;
      inflight_drop <= 1'b0;
    end else if (issue) begin
      inflight      <= 1'b1;
      inflight_we   <= head_we;
      inflight_drop <= 1'b0;
    end else begin
      if (pi1_rdy_i) inflight <= 1'b0;
      if (!wb4_cyc_i && inflight) inflight_drop <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb4_ack_o  <= 1'b0;
      wb4_data_o <= '0;
    end else begin
      wb4_ack_o  <= complete;
      wb4_data_o <= (complete && !inflight_we) ? pi1_data_i : '0;
    end
  end

endmodule
